// File: rtl/key_debounce_pkg.sv
// Shared board-I/O definitions: debounce defaults for the 50 MHz system clock,
// the per-key state encoding and a constant-evaluable ceiling log2.
package key_debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic {
        KEY_IDLE    = 1'b0,
        KEY_PRESSED = 1'b1
    } key_state_e;

    // Returns 0 for values <= 1; callers clamp to a minimum width themselves.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One debounced key line: 2-FF synchronizer, stability counter, pressed/released
// state bit and registered single-cycle press/release pulses.
module key_debounce_bit
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_in,
    output logic key_stable,
    output logic key_stable_next,
    output logic key_press,
    output logic key_release
);

    localparam int CNT_W = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    key_state_e       state;
    key_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             press_next;
    logic             release_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            state       <= KEY_IDLE;
            cnt         <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= key_in;
            sync2       <= sync1;
            state       <= state_next;
            cnt         <= cnt_next;
            key_press   <= press_next;
            key_release <= release_next;
        end
    end

    // Any return to the accepted level clears the count, so bounces never
    // accumulate; the counter stops at CNT_MAX because the state flips there.
    always_comb begin
        state_next   = state;
        cnt_next     = '0;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (sync2 != logic'(state)) begin
            if (cnt == CNT_MAX) begin
                if (state == KEY_IDLE) begin
                    state_next = KEY_PRESSED;
                    press_next = 1'b1;
                end else begin
                    state_next   = KEY_IDLE;
                    release_next = 1'b1;
                end
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    assign key_stable      = (state == KEY_PRESSED);
    assign key_stable_next = (state_next == KEY_PRESSED);

endmodule

// File: rtl/key_debounce.sv
// Key conditioning ahead of the key PIO: polarity normalization, WIDTH
// independent debouncers and a registered any-key-pressed flag.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_stable,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    output logic             key_any
);

    logic [WIDTH-1:0] key_norm;
    logic [WIDTH-1:0] stable_next;

    assign key_norm = key_raw ^ {WIDTH{ACTIVE_LOW}};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        key_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk            (clk),
            .reset_n        (reset_n),
            .key_in         (key_norm[i]),
            .key_stable     (key_stable[i]),
            .key_stable_next(stable_next[i]),
            .key_press      (key_press[i]),
            .key_release    (key_release[i])
        );
    end

    // Built from next-state so key_any moves on the same edge as key_stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_any <= 1'b0;
        end else begin
            key_any <= |stable_next;
        end
    end

endmodule
